c157x_sd_arbiter: RTL and testbench
===================================

// Module: c157x_sd_arbiter
// PURPOSE
// Shares one MiSTer SD block port (sd_rd/sd_wr/sd_lba/sd_blk_cnt/sd_ack/buff) between NDRV
// c157x drive instances, e.g. units 8 and 9 on one image slot. Lives in the clk_sys domain
// between the drive track-loaders and the HPS SD interface. Grants round-robin; a grant is held
// for the whole transfer. Aborts requests the host never acknowledges, and reports an error pulse.
// PARAMETERS
// NDRV   2    number of requesting drives (2..4)
// TO_W   24   width of REQ-phase watchdog counter; timeout = 2**TO_W-1 clk cycles
// PORTS
// clk          in   1         clk_sys
// reset        in   1         synchronous, active-high
// drv_rd       in   NDRV      per-drive read request, level, held until its drv_ack rises
// drv_wr       in   NDRV      per-drive write request, level, held until its drv_ack rises
// drv_lba      in   NDRV*32   per-drive LBA, drive i at [32*i+:32]
// drv_blk_cnt  in   NDRV*6    per-drive block count-1, drive i at [6*i+:6]
// drv_buff_din in   NDRV*8    per-drive write data, drive i at [8*i+:8]
// drv_ack      out  NDRV      sd_ack routed to granted drive only
// drv_buff_wr  out  NDRV      sd_buff_wr routed to granted drive only
// drv_err      out  NDRV      1-cycle pulse: request of drive i timed out
// sd_rd        out  1         to host
// sd_wr        out  1         to host
// sd_lba       out  32        latched LBA of granted request
// sd_blk_cnt   out  6         latched block count of granted request
// sd_buff_din  out  8         drv_buff_din of granted drive (combinational mux on gnt)
// sd_ack       in   1         host transfer acknowledge
// sd_buff_wr   in   1         host buffer write strobe
// gnt          out  2         index of granted drive (valid when busy=1)
// busy         out  1         1 in any state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE, sd_rd/sd_wr=0, sd_lba=0, sd_blk_cnt=0, gnt=0, rr pointer=0,
//   drv_ack/drv_buff_wr/drv_err=0, busy=0. Reset mid-transfer drops sd_rd/sd_wr next cycle.
// - States: IDLE, REQ, XFER, DONE.
// - IDLE: no grant while sd_ack=1 (drains a host transfer left over by reset/timeout). Otherwise
//   the first drive with (drv_rd|drv_wr) scanning rr, rr+1, ... mod NDRV wins. Same edge: latch
//   gnt, lba, blk_cnt, op (wr wins if both rd and wr set) -> REQ. 1-cycle latency to sd_rd/sd_wr.
// - REQ: sd_rd or sd_wr = latched op; watchdog counts up from 0.
//   sd_ack=1 -> XFER, and sd_rd/sd_wr drop on that same edge.
//   granted request withdrawn (both rd and wr =0) before sd_ack -> IDLE, no ack, no err.
//   watchdog all-ones -> drv_err[gnt] pulse, sd_rd/sd_wr=0, rr=gnt+1 -> IDLE.
// - XFER: drv_ack[gnt]=sd_ack, drv_buff_wr[gnt]=sd_buff_wr. All other drives see 0.
//   sd_ack=0 -> DONE.
// - DONE: one cycle; rr=gnt+1 mod NDRV -> IDLE. The drive must have dropped its request by now.
//   If it is still asserted in IDLE, that is treated as a new request.
// - drv_ack and drv_buff_wr are combinational from sd_ack/sd_buff_wr gated by state==XFER and gnt,
//   so there is no added latency on buffer strobes. sd_buff_din = drv_buff_din[gnt] in all states.
// - Requests changing lba/blk_cnt after grant are ignored until the next grant.
// - Watchdog is cleared on every entry to REQ. rr arithmetic wraps modulo NDRV
//   (NDRV=3: 2 -> 0).
// TESTING
// 1 single: drv_rd=01, lba0=0x120, cnt0=30 -> sd_rd=1 next clk, sd_lba=0x120, sd_blk_cnt=30;
//   ack 512 clk with 10 buff_wr -> drv_ack=01, 10 drv_buff_wr[0] pulses, busy=0 two clk after ack falls
// 2 contention: drv_rd=11 after reset -> drive0 served first, then drive1; repeat with rr=1 ->
//   drive1 first; drv_buff_wr[1] never pulses during the drive0 transfer
// 3 rd+wr same drive: drv_rd[1]=drv_wr[1]=1 -> sd_wr=1, sd_rd=0, sd_buff_din tracks drv_buff_din[1]
// 4 timeout (TO_W=4): drv_wr=01, sd_ack held 0 -> sd_wr drops after 15 clk, drv_err=01 for 1 clk;
//   pending drv_rd[1] granted next
// 5 withdraw: drv_rd[0] drops in REQ before sd_ack -> IDLE, sd_rd=0, no drv_ack, no drv_err
// 6 reset mid-XFER with sd_ack=1: outputs 0; drv_rd=10 not granted until sd_ack=0, then sd_rd=1

Source files
------------

// File: rtl/c157x_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : c157x_sd_arbiter
//  Purpose  : Shares one MiSTer SD block port between NDRV c157x drive
//             instances (clk_sys domain). Grants are round-robin and are held
//             for a whole transfer. A request the host never acknowledges is
//             aborted by a watchdog, and the drive gets a 1-cycle error pulse.
//  Ports    : clk, reset            - clk_sys, synchronous active-high reset
//             drv_rd/drv_wr         - per-drive level requests
//             drv_lba/drv_blk_cnt   - per-drive LBA / block count-1 (packed)
//             drv_buff_din          - per-drive write data (packed)
//             drv_ack/drv_buff_wr   - host strobes routed to the granted drive
//             drv_err               - per-drive timeout pulse
//             sd_rd/sd_wr/sd_lba/sd_blk_cnt/sd_buff_din - to host
//             sd_ack/sd_buff_wr     - from host
//             gnt/busy              - granted drive index / arbiter active
//  Revision : 1.0 - initial release
// ============================================================================
module c157x_sd_arbiter #(
    parameter int NDRV = 2,
    parameter int TO_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NDRV-1:0]      drv_rd,
    input  logic [NDRV-1:0]      drv_wr,
    input  logic [NDRV*32-1:0]   drv_lba,
    input  logic [NDRV*6-1:0]    drv_blk_cnt,
    input  logic [NDRV*8-1:0]    drv_buff_din,
    output logic [NDRV-1:0]      drv_ack,
    output logic [NDRV-1:0]      drv_buff_wr,
    output logic [NDRV-1:0]      drv_err,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [31:0]          sd_lba,
    output logic [5:0]           sd_blk_cnt,
    output logic [7:0]           sd_buff_din,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic [1:0]           gnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_gnt;
    logic [1:0]      r_rr;
    logic            r_sd_rd;
    logic            r_sd_wr;
    logic [31:0]     r_lba;
    logic [5:0]      r_cnt;
    logic [NDRV-1:0] r_err;
    logic [TO_W-1:0] r_wd;

    logic [TO_W-1:0] w_wd_inc;
    logic [3:0]      w_req;
    logic            w_found;
    logic [1:0]      w_pick;
    logic [2:0]      w_scan;
    logic            w_pick_wr;
    logic [31:0]     w_pick_lba;
    logic [5:0]      w_pick_cnt;
    logic [7:0]      w_din;
    logic            w_grant;
    logic            w_timeout;
    logic            w_withdrawn;
    logic            w_to_fire;
    logic [1:0]      w_rr_nxt;

    // Request vector padded to 4 bits so it can be indexed by any 2-bit id.
    always_comb begin
        w_req = 4'b0000;
        for (int i = 0; i < NDRV; i++) begin
            w_req[i] = drv_rd[i] | drv_wr[i];
        end
    end

    // Round-robin scan: rr, rr+1, ... wrapping modulo NDRV. rr < NDRV and
    // k < NDRV, so a single conditional subtract performs the wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_scan  = 3'd0;
        for (int k = 0; k < NDRV; k++) begin
            w_scan = {1'b0, r_rr} + 3'(k);
            if (w_scan >= 3'(NDRV)) begin
                w_scan = w_scan - 3'(NDRV);
            end
            if (!w_found && w_req[w_scan[1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[1:0];
            end
        end
    end

    // Field muxes: candidate winner's request, and the granted drive's data.
    always_comb begin
        w_pick_wr  = 1'b0;
        w_pick_lba = 32'd0;
        w_pick_cnt = 6'd0;
        w_din      = 8'd0;
        for (int i = 0; i < NDRV; i++) begin
            if (w_pick == 2'(i)) begin
                w_pick_wr  = drv_wr[i];
                w_pick_lba = drv_lba[32*i +: 32];
                w_pick_cnt = drv_blk_cnt[6*i +: 6];
            end
            if (r_gnt == 2'(i)) begin
                w_din = drv_buff_din[8*i +: 8];
            end
        end
    end

    // The watchdog holds the number of REQ cycles already elapsed; the request
    // is abandoned once that count reaches all-ones, so the host sees the
    // request for exactly 2**TO_W-1 cycles.
    assign w_wd_inc    = r_wd + TO_W'(1);
    assign w_timeout   = &w_wd_inc;
    assign w_withdrawn = ~w_req[r_gnt];
    assign w_to_fire   = (r_state == ST_REQ) && !sd_ack && !w_withdrawn && w_timeout;
    // A host transfer still running (e.g. across a reset) blocks new grants.
    assign w_grant     = (r_state == ST_IDLE) && !sd_ack && w_found;
    assign w_rr_nxt    = (r_gnt == 2'(NDRV-1)) ? 2'd0 : r_gnt + 2'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (sd_ack)           w_state_nxt = ST_XFER;
                else if (w_withdrawn) w_state_nxt = ST_IDLE;
                else if (w_timeout)   w_state_nxt = ST_IDLE;
            end
            ST_XFER: if (!sd_ack) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'd0;
            r_rr    <= 2'd0;
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_lba   <= 32'd0;
            r_cnt   <= 6'd0;
            r_err   <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            for (int i = 0; i < NDRV; i++) begin
                r_err[i] <= w_to_fire && (r_gnt == 2'(i));
            end
            case (r_state)
                ST_IDLE: begin
                    r_wd <= '0;
                    if (w_grant) begin
                        r_gnt   <= w_pick;
                        r_lba   <= w_pick_lba;
                        r_cnt   <= w_pick_cnt;
                        // Write wins when a drive raises both rd and wr.
                        r_sd_wr <= w_pick_wr;
                        r_sd_rd <= ~w_pick_wr;
                    end
                end
                ST_REQ: begin
                    r_wd <= w_wd_inc;
                    if (sd_ack || w_withdrawn || w_timeout) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                    end
                    if (w_to_fire) begin
                        r_rr <= w_rr_nxt;
                    end
                end
                ST_DONE: r_rr <= w_rr_nxt;
                default: ;
            endcase
        end
    end

    // Host strobes pass straight through to the granted drive so buffer
    // writes see no added latency.
    generate
        for (genvar i = 0; i < NDRV; i++) begin : g_route
            assign drv_ack[i]     = (r_state == ST_XFER) && (r_gnt == 2'(i)) && sd_ack;
            assign drv_buff_wr[i] = (r_state == ST_XFER) && (r_gnt == 2'(i)) && sd_buff_wr;
        end
    endgenerate

    assign drv_err     = r_err;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign sd_lba      = r_lba;
    assign sd_blk_cnt  = r_cnt;
    assign sd_buff_din = w_din;
    assign gnt         = r_gnt;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_c157x_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c157x_sd_arbiter
//  Purpose  : Directed self-checking bench for c157x_sd_arbiter (NDRV=2,
//             TO_W=4). Expected grants are queued when a request is driven
//             and compared when the arbiter raises sd_rd/sd_wr.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_c157x_sd_arbiter;

    localparam int NDRV = 2;
    localparam int TO_W = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NDRV-1:0]     drv_rd;
    logic [NDRV-1:0]     drv_wr;
    logic [NDRV*32-1:0]  drv_lba;
    logic [NDRV*6-1:0]   drv_blk_cnt;
    logic [NDRV*8-1:0]   drv_buff_din;
    logic [NDRV-1:0]     drv_ack;
    logic [NDRV-1:0]     drv_buff_wr;
    logic [NDRV-1:0]     drv_err;
    logic                sd_rd;
    logic                sd_wr;
    logic [31:0]         sd_lba;
    logic [5:0]          sd_blk_cnt;
    logic [7:0]          sd_buff_din;
    logic                sd_ack;
    logic                sd_buff_wr;
    logic [1:0]          gnt;
    logic                busy;

    c157x_sd_arbiter #(.NDRV(NDRV), .TO_W(TO_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_lba      (drv_lba),
        .drv_blk_cnt  (drv_blk_cnt),
        .drv_buff_din (drv_buff_din),
        .drv_ack      (drv_ack),
        .drv_buff_wr  (drv_buff_wr),
        .drv_err      (drv_err),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_buff_din  (sd_buff_din),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .gnt          (gnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  drv;
        logic        wr;
        logic [31:0] lba;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int bw_cnt [NDRV];
    int ack_cnt[NDRV];
    int err_cnt[NDRV];

    initial begin
        for (int i = 0; i < NDRV; i++) begin
            bw_cnt[i]  = 0;
            ack_cnt[i] = 0;
            err_cnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NDRV; i++) begin
            if (drv_buff_wr[i]) bw_cnt[i]  <= bw_cnt[i] + 1;
            if (drv_ack[i])     ack_cnt[i] <= ack_cnt[i] + 1;
            if (drv_err[i])     err_cnt[i] <= err_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input int d, input logic rd, input logic wr,
                           input logic [31:0] lba, input logic [5:0] cnt);
        drv_rd[d]            = rd;
        drv_wr[d]            = wr;
        drv_lba[32*d +: 32]  = lba;
        drv_blk_cnt[6*d +: 6] = cnt;
        sb.push_back('{drv: 2'(d), wr: wr, lba: lba, cnt: cnt});
    endtask

    // Wait (bounded) for the host request, then compare it with the oldest
    // queued expectation.
    task automatic expect_grant(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!(sd_rd | sd_wr) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " grant_seen"}, 32'(sd_rd | sd_wr), 32'd1);
        if (!(sd_rd | sd_wr)) return;
        chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, " gnt"},    32'(gnt),        32'(e.drv));
        chk({tag, " sd_wr"},  32'(sd_wr),      32'(e.wr));
        chk({tag, " sd_rd"},  32'(sd_rd),      32'(!e.wr));
        chk({tag, " lba"},    sd_lba,          e.lba);
        chk({tag, " blkcnt"}, 32'(sd_blk_cnt), 32'(e.cnt));
        chk({tag, " busy"},   32'(busy),       32'd1);
    endtask

    // Host acknowledges for len cycles with npulse buffer strobes; the drive
    // drops its request once it sees its ack.
    task automatic host_xfer(input string tag, input int d, input int len, input int npulse);
        int              bw0 [NDRV];
        int              ack0[NDRV];
        logic [NDRV-1:0] oh;
        oh    = '0;
        oh[d] = 1'b1;
        for (int i = 0; i < NDRV; i++) begin
            bw0[i]  = bw_cnt[i];
            ack0[i] = ack_cnt[i];
        end
        sd_ack = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk({tag, " ack_route"}, 32'(drv_ack), 32'(oh));
                chk({tag, " req_drop"},  32'({sd_rd, sd_wr}), 32'd0);
                drv_rd[d] = 1'b0;
                drv_wr[d] = 1'b0;
            end
            sd_buff_wr = (k % 4 == 1) && (k / 4 < npulse);
        end
        @(negedge clk);
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        @(negedge clk);
        chk({tag, " busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        for (int i = 0; i < NDRV; i++) begin
            chk({tag, " buff_wr_count"}, 32'(bw_cnt[i] - bw0[i]), 32'((i == d) ? npulse : 0));
            if (i != d) chk({tag, " stray_ack"}, 32'(ack_cnt[i] - ack0[i]), 32'd0);
        end
    endtask

    initial begin
        int n;
        int err0[NDRV];
        int ack0[NDRV];

        reset        = 1'b1;
        drv_rd       = '0;
        drv_wr       = '0;
        drv_lba      = '0;
        drv_blk_cnt  = '0;
        drv_buff_din = '0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst busy",    32'(busy),       32'd0);
        chk("rst sd_rd",   32'(sd_rd),      32'd0);
        chk("rst sd_wr",   32'(sd_wr),      32'd0);
        chk("rst gnt",     32'(gnt),        32'd0);
        chk("rst lba",     sd_lba,          32'd0);
        chk("rst blkcnt",  32'(sd_blk_cnt), 32'd0);
        chk("rst drv_err", 32'(drv_err),    32'd0);
        chk("rst drv_ack", 32'(drv_ack),    32'd0);
        reset = 1'b0;

        // 1: single drive read
        request(0, 1'b1, 1'b0, 32'h120, 6'd30);
        @(negedge clk);
        chk("t1 latency", 32'(sd_rd), 32'd1);
        expect_grant("t1");
        host_xfer("t1", 0, 512, 10);

        // 2: contention from rr=0, then from rr=1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        request(0, 1'b1, 1'b0, 32'hA000_0001, 6'd5);
        request(1, 1'b1, 1'b0, 32'hB000_0002, 6'd7);
        expect_grant("t2a");
        host_xfer("t2a", 0, 12, 3);
        expect_grant("t2b");
        host_xfer("t2b", 1, 8, 2);
        request(0, 1'b1, 1'b0, 32'hC000_0003, 6'd1);
        expect_grant("t2c");
        host_xfer("t2c", 0, 4, 1);
        request(1, 1'b1, 1'b0, 32'hD000_0004, 6'd2);
        request(0, 1'b1, 1'b0, 32'hE000_0005, 6'd3);
        expect_grant("t2d");
        host_xfer("t2d", 1, 8, 2);
        expect_grant("t2e");
        host_xfer("t2e", 0, 8, 2);

        // 3: rd+wr on the same drive -> write; data mux follows drive 1
        drv_buff_din = {8'hA5, 8'h3C};
        request(1, 1'b1, 1'b1, 32'h0BAD_F00D, 6'd9);
        expect_grant("t3");
        chk("t3 din_a", 32'(sd_buff_din), 32'h0000_00A5);
        drv_buff_din = {8'h5A, 8'hFF};
        #1;
        chk("t3 din_b", 32'(sd_buff_din), 32'h0000_005A);
        host_xfer("t3", 1, 8, 2);

        // 4: watchdog timeout, pending drive 1 served next
        for (int i = 0; i < NDRV; i++) err0[i] = err_cnt[i];
        request(0, 1'b0, 1'b1, 32'h0000_0E0E, 6'd3);
        request(1, 1'b1, 1'b0, 32'h0000_0F0F, 6'd4);
        expect_grant("t4a");
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!sd_wr) break;
            n++;
        end
        chk("t4 req_cycles", 32'(n), 32'(2**TO_W - 1));
        chk("t4 err_pulse",  32'(drv_err), 32'b01);
        drv_wr[0] = 1'b0;
        @(negedge clk);
        chk("t4 err_clear", 32'(drv_err), 32'b00);
        chk("t4 err_count0", 32'(err_cnt[0] - err0[0]), 32'd1);
        chk("t4 err_count1", 32'(err_cnt[1] - err0[1]), 32'd0);
        expect_grant("t4b");
        host_xfer("t4b", 1, 8, 2);

        // 5: withdraw in REQ before the host acks
        for (int i = 0; i < NDRV; i++) begin
            err0[i] = err_cnt[i];
            ack0[i] = ack_cnt[i];
        end
        request(0, 1'b1, 1'b0, 32'h0000_5555, 6'd2);
        expect_grant("t5");
        drv_rd[0] = 1'b0;
        @(negedge clk);
        chk("t5 sd_rd", 32'(sd_rd), 32'd0);
        chk("t5 busy",  32'(busy),  32'd0);
        repeat (3) @(negedge clk);
        chk("t5 no_err", 32'(err_cnt[0] - err0[0]), 32'd0);
        chk("t5 no_ack", 32'(ack_cnt[0] - ack0[0]), 32'd0);

        // 6: reset during XFER with the host ack still high
        request(0, 1'b1, 1'b0, 32'h0000_6666, 6'd1);
        expect_grant("t6a");
        sd_ack = 1'b1;
        @(negedge clk);
        chk("t6 ack_route", 32'(drv_ack), 32'b01);
        reset = 1'b1;
        @(negedge clk);
        chk("t6 rst sd_rd",   32'(sd_rd),   32'd0);
        chk("t6 rst busy",    32'(busy),    32'd0);
        chk("t6 rst drv_ack", 32'(drv_ack), 32'd0);
        drv_rd[0] = 1'b0;
        reset     = 1'b0;
        request(1, 1'b1, 1'b0, 32'h0000_7777, 6'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6 drain_hold", 32'({busy, sd_rd}), 32'd0);
        end
        sd_ack = 1'b0;
        @(negedge clk);
        chk("t6 grant_after_drain", 32'(sd_rd), 32'd1);
        expect_grant("t6b");
        host_xfer("t6b", 1, 8, 2);

        chk("sb drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
